// File: rtl/clock_monitor_1mhz_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_monitor_1mhz_pkg : shared constants and FSM encoding for the monitor.
// Revision 1.0
// ---------------------------------------------------------------------------
package clock_monitor_1mhz_pkg;

  localparam int SYS_CLK_MHZ     = 26;
  localparam int MON_CLK_MHZ     = 1;
  localparam int DIV_FACTOR      = SYS_CLK_MHZ / MON_CLK_MHZ;
  localparam int NOMINAL_DEFAULT = DIV_FACTOR;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_ACQUIRE = 2'd1;
  localparam logic [1:0] c_ST_LOCKED  = 2'd2;
  localparam logic [1:0] c_ST_FAULT   = 2'd3;

  // Counter must be able to represent the saturation value 2*nominal.
  function automatic int min_cnt_w(input int nominal);
    return $clog2(2 * nominal + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_edge_detect : two-flop synchroniser plus delay flop, rising-edge pulse.
// Revision 1.0
// ---------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_sync3;

endmodule
`default_nettype wire

// File: rtl/clock_monitor_1mhz.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_monitor_1mhz : measures the 1 MHz clock period in 26 MHz cycles and
// tracks lock / sticky fault.                                   Revision 1.0
// ---------------------------------------------------------------------------
module clock_monitor_1mhz
  import clock_monitor_1mhz_pkg::*;
#(
  parameter int NOMINAL    = NOMINAL_DEFAULT,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 8,
  parameter int CNT_W      = 8
) (
  input  logic             CLK_26MHZ_IN,
  input  logic             RESET_N,
  input  logic             CLK_1MHZ_IN,
  input  logic             CLEAR_FAULT_IN,
  output logic             TICK_OUT,
  output logic [CNT_W-1:0] PERIOD_OUT,
  output logic             PERIOD_VALID_OUT,
  output logic             LOCKED_OUT,
  output logic             FAULT_OUT
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] c_SAT    = CNT_W'(2 * NOMINAL);
  localparam logic [CNT_W-1:0] c_SAT_M1 = CNT_W'(2 * NOMINAL - 1);
  localparam logic [CNT_W-1:0] c_LO     = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] c_HI     = CNT_W'(NOMINAL + TOL);
  localparam logic [RUN_W-1:0] c_LOCK   = RUN_W'(LOCK_COUNT);

  generate
    if (CNT_W < min_cnt_w(NOMINAL)) begin : g_cnt_w_check
      $error("CNT_W too narrow to hold 2*NOMINAL");
    end
  endgenerate

  logic             w_rise;
  logic             w_clear;
  logic             w_valid;
  logic             w_good;
  logic             w_timeout;
  logic [1:0]       w_state_nxt;
  logic [RUN_W-1:0] w_run_nxt;

  logic [1:0]       r_state;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_tick;
  logic             r_pvalid;

  sync_edge_detect u_sync (
    .clk    (CLK_26MHZ_IN),
    .rst_n  (RESET_N),
    .i_async(CLK_1MHZ_IN),
    .o_rise (w_rise)
  );

  // A clear coinciding with an edge wins: that edge is treated as a first edge.
  assign w_clear   = CLEAR_FAULT_IN && (r_state == c_ST_FAULT);
  assign w_valid   = w_rise && (r_state != c_ST_IDLE) && !w_clear;
  assign w_good    = (r_cnt >= c_LO) && (r_cnt <= c_HI);
  // Fires only on the step into saturation, so a stall is seen once.
  assign w_timeout = !w_rise && (r_cnt == c_SAT_M1);

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;

    if (w_valid) begin
      if (!w_good) begin
        w_run_nxt = '0;
      end else if (r_run != c_LOCK) begin
        w_run_nxt = r_run + 1'b1;
      end
    end

    case (r_state)
      c_ST_IDLE: begin
        w_run_nxt = '0;
        if (w_rise) begin
          w_state_nxt = c_ST_ACQUIRE;
        end
      end
      c_ST_ACQUIRE: begin
        if (w_timeout) begin
          w_state_nxt = c_ST_IDLE;
          w_run_nxt   = '0;
        end else if (w_valid && w_good && (w_run_nxt == c_LOCK)) begin
          w_state_nxt = c_ST_LOCKED;
        end
      end
      c_ST_LOCKED: begin
        if (w_timeout || (w_valid && !w_good)) begin
          w_state_nxt = c_ST_FAULT;
        end
      end
      c_ST_FAULT: begin
        if (w_clear) begin
          w_run_nxt   = '0;
          w_state_nxt = w_rise ? c_ST_ACQUIRE : c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_26MHZ_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= c_ST_IDLE;
      r_run    <= '0;
      r_cnt    <= '0;
      r_period <= '0;
      r_tick   <= 1'b0;
      r_pvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_tick   <= w_rise;
      r_pvalid <= w_valid;
      if (w_valid) begin
        r_period <= r_cnt;
      end
      if (w_rise) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != c_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign TICK_OUT         = r_tick;
  assign PERIOD_OUT       = r_period;
  assign PERIOD_VALID_OUT = r_pvalid;
  assign LOCKED_OUT       = (r_state == c_ST_LOCKED);
  assign FAULT_OUT        = (r_state == c_ST_FAULT);

endmodule
`default_nettype wire
